// File: rtl/press_pkg.sv
// Shared types for the press classifier: FSM states and event codes.
// Combinational definitions only; no timing or flow-control behaviour.
package press_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRESS1    = 3'd1,
      LONG_HELD = 3'd2,
      WAIT2     = 3'd3,
      PRESS2    = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      EVT_NONE   = 2'b00,
      EVT_SHORT  = 2'b01,
      EVT_LONG   = 2'b10,
      EVT_DOUBLE = 2'b11
   } evt_code_t;

   localparam int CNT_W = 16;

endpackage

// File: rtl/evt_hold_reg.sv
// Single-entry valid/ready event holding register with sticky overflow flag.
// Load-to-valid 1 cycle; a load while full and not accepted is dropped and flagged.
module evt_hold_reg
   import press_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      load,
   input  evt_code_t load_code,
   input  logic      evt_ready,
   output logic      evt_valid,
   output evt_code_t evt_code,
   output logic      overflow
);

   logic accept;

   assign accept = evt_valid & evt_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         evt_valid <= 1'b0;
         evt_code  <= EVT_NONE;
         overflow  <= 1'b0;
      end else if (load && (!evt_valid || accept)) begin
         evt_valid <= 1'b1;
         evt_code  <= load_code;
      end else if (load) begin
         // slot still owned by an unaccepted event: keep it, lose the new one
         overflow  <= 1'b1;
      end else if (accept) begin
         evt_valid <= 1'b0;
         evt_code  <= EVT_NONE;
      end
   end

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button presses into SHORT, LONG and DOUBLE events.
// Event visible 1 cycle after classification; held until accepted, extra events set overflow.
module press_classifier
   import press_pkg::*;
#(
   parameter int LONG_CYCLES   = 8,
   parameter int DCLICK_CYCLES = 4
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       db_level,
   input  logic       db_tick,
   output logic       evt_valid,
   output logic [1:0] evt_code,
   input  logic       evt_ready,
   output logic       overflow
);

   localparam logic [CNT_W-1:0] LONG_LAST   = 16'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] DCLICK_LAST = 16'(DCLICK_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             lvl_q;
   logic             release_evt;
   logic             cls_vld;
   evt_code_t        cls_code;
   evt_code_t        hold_code;

   assign release_evt = ~db_level & lvl_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         lvl_q <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         lvl_q <= db_level;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cls_vld   = 1'b0;
      cls_code  = EVT_NONE;
      case (state)
         IDLE: begin
            if (db_tick) begin
               state_nxt = PRESS1;
               cnt_nxt   = '0;
            end
         end
         PRESS1: begin
            cnt_nxt = cnt + 16'd1;
            // release wins over reaching the long threshold in the same cycle
            if (release_evt) begin
               state_nxt = WAIT2;
               cnt_nxt   = '0;
            end else if (cnt == LONG_LAST) begin
               state_nxt = LONG_HELD;
               cls_vld   = 1'b1;
               cls_code  = EVT_LONG;
            end
         end
         LONG_HELD: begin
            if (release_evt) state_nxt = IDLE;
         end
         WAIT2: begin
            cnt_nxt = cnt + 16'd1;
            if (db_tick) begin
               state_nxt = PRESS2;
            end else if (cnt == DCLICK_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               cls_vld   = 1'b1;
               cls_code  = EVT_SHORT;
            end
         end
         PRESS2: begin
            if (release_evt) begin
               state_nxt = IDLE;
               cls_vld   = 1'b1;
               cls_code  = EVT_DOUBLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   evt_hold_reg u_hold (
      .clk       (clk),
      .reset     (reset),
      .load      (cls_vld),
      .load_code (cls_code),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_code  (hold_code),
      .overflow  (overflow)
   );

   assign evt_code = hold_code;

endmodule
